// File: rtl/score_controller_if.sv
// Hit-request / score bundle between the collision logic, score_controller
// and score_display. The master drives hits and restart; the slave (the
// score controller) returns the score, strobes and status.
interface score_controller_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] hit_req;
  logic               clear_score;
  logic [15:0]        score_bcd;
  logic [15:0]        high_bcd;
  logic               score_update;
  logic [NUM_REQ-1:0] hit_ack;
  logic               hit_dropped;
  logic               busy;

  modport master (
    output hit_req, clear_score,
    input  score_bcd, high_bcd, score_update, hit_ack, hit_dropped, busy
  );

  modport slave (
    input  hit_req, clear_score,
    output score_bcd, high_bcd, score_update, hit_ack, hit_dropped, busy
  );
endinterface

// File: rtl/score_controller.sv
// Score update sequencer: edge-detects hits from NUM_REQ requesters, queues
// them in saturating pending counters, grants them round-robin onto a
// digit-serial BCD adder and commits the saturating 4-digit score.
//
// state  | meaning
// IDLE   | waiting for any pending hit; picks the next grant
// ADD    | adds one BCD digit per cycle, digits 0..3, into temp
// COMMIT | writes temp (or 9999 on overflow) to the score, strobes ack
module score_controller #(
  parameter int          NUM_REQ    = 4,
  parameter logic [15:0] POINTS_BCD = 16'h0010,
  parameter int          PEND_W     = 2
) (
  input logic               clk_100MHz,
  input logic               reset_n,
  score_controller_if.slave sc
);
  localparam int                RW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int                RW1      = RW + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [RW1-1:0]    NREQ_W   = RW1'(NUM_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, COMMIT = 2'd2} state_t;
  state_t state_q, state_d;

  logic [NUM_REQ-1:0] prev_q, rise, dec_vec, drop_vec, hit_ack_q;
  logic [PEND_W-1:0]  pend_q [NUM_REQ];
  logic [RW-1:0]      rr_q, grant_q, grant_d, search_idx, rr_next;
  logic               found;
  logic [1:0]         digit_q, digit_d;
  logic               carry_q, carry_d;
  logic [15:0]        temp_q, temp_d, score_q, high_q, new_score;
  logic [3:0]         score_nib, point_nib;
  logic [4:0]         sum, sum_adj;
  logic               commit, clear;
  logic               score_update_q, hit_dropped_q, busy_q;

  assign clear     = sc.clear_score;
  assign rise      = sc.hit_req & ~prev_q;
  // Overflow out of the thousands digit pins the score at 9999.
  assign new_score = carry_q ? 16'h9999 : temp_q;
  assign score_nib = score_q[{digit_q, 2'b00} +: 4];
  assign point_nib = POINTS_BCD[{digit_q, 2'b00} +: 4];
  assign sum       = {1'b0, score_nib} + {1'b0, point_nib} + {4'b0000, carry_q};
  assign sum_adj   = sum - 5'd10;

  // First requester with pending hits, searching upward from rr with wrap.
  always_comb begin
    logic [RW1-1:0] cand;
    found      = 1'b0;
    search_idx = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + RW1'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && (pend_q[cand[RW-1:0]] != '0)) begin
        found      = 1'b1;
        search_idx = cand[RW-1:0];
      end
    end
  end

  // Pointer value that follows the current grant.
  always_comb begin
    logic [RW1-1:0] inc;
    inc     = {1'b0, grant_q} + RW1'(1);
    rr_next = (inc >= NREQ_W) ? '0 : inc[RW-1:0];
  end

  // Per-requester commit and drop qualifiers.
  always_comb begin
    dec_vec  = '0;
    drop_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec_vec[i]  = commit && (grant_q == RW'(i));
      drop_vec[i] = rise[i] && !clear && (pend_q[i] == PEND_MAX) && !dec_vec[i];
    end
  end

  // State register.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, grant latch and digit-serial adder; restart overrides all.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    digit_d = digit_q;
    carry_d = carry_q;
    temp_d  = temp_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ADD;
          grant_d = search_idx;
          digit_d = 2'd0;
          carry_d = 1'b0;
        end
      end
      ADD: begin
        if (sum > 5'd9) begin
          temp_d[{digit_q, 2'b00} +: 4] = sum_adj[3:0];
          carry_d = 1'b1;
        end else begin
          temp_d[{digit_q, 2'b00} +: 4] = sum[3:0];
          carry_d = 1'b0;
        end
        digit_d = digit_q + 2'd1;
        if (digit_q == 2'd3) state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      digit_d = 2'd0;
      carry_d = 1'b0;
      temp_d  = '0;
      commit  = 1'b0;
    end
  end

  // Datapath, score/high registers and registered output strobes.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      grant_q        <= '0;
      digit_q        <= 2'd0;
      carry_q        <= 1'b0;
      temp_q         <= '0;
      score_q        <= '0;
      high_q         <= '0;
      rr_q           <= '0;
      score_update_q <= 1'b0;
      hit_ack_q      <= '0;
      hit_dropped_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      grant_q        <= grant_d;
      digit_q        <= digit_d;
      carry_q        <= carry_d;
      temp_q         <= temp_d;
      score_update_q <= commit;
      hit_ack_q      <= commit ? (NUM_REQ'(1) << grant_q) : '0;
      hit_dropped_q  <= |drop_vec;
      busy_q         <= (state_d != IDLE);
      if (clear)       score_q <= '0;
      else if (commit) score_q <= new_score;
      if (commit && (new_score > high_q)) high_q <= new_score;
      if (commit) rr_q <= rr_next;
    end
  end

  // Edge detect history and saturating pending-hit counters.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) pend_q[i] <= '0;
    end else begin
      prev_q <= sc.hit_req;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (clear) begin
          pend_q[i] <= '0;
        end else if (rise[i] && !dec_vec[i]) begin
          if (pend_q[i] != PEND_MAX) pend_q[i] <= pend_q[i] + 1'b1;
        end else if (dec_vec[i] && !rise[i]) begin
          pend_q[i] <= pend_q[i] - 1'b1;
        end
      end
    end
  end

  assign sc.score_bcd    = score_q;
  assign sc.high_bcd     = high_q;
  assign sc.score_update = score_update_q;
  assign sc.hit_ack      = hit_ack_q;
  assign sc.hit_dropped  = hit_dropped_q;
  assign sc.busy         = busy_q;
endmodule
